// File: rtl/bls12_381_fe12_stream_rx.sv
// BLS12-381 Fp12 stream receiver: packs a 12-beat stream of Fp words into one
// fe12 element, tags it with the sideband control word from the first beat,
// and flags malformed frames or out-of-range words.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting beats into slots 0..11, cnt = next slot
// HOLD    | frame complete, o_val high, waiting for downstream i_rdy
// DRAIN   | 12 words stored without eop; discarding beats until eop

package bls12_381_pkg;
    localparam int FE_BITS = 381;
    typedef logic [FE_BITS-1:0] fe_t;
    localparam fe_t P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
endpackage

module bls12_381_fe12_stream_rx #(
    parameter int                 CTL_BITS    = 8,
    parameter bls12_381_pkg::fe_t P           = bls12_381_pkg::P,
    parameter bit                 CHECK_RANGE = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_val,
    output logic                  o_rdy,
    input  logic [380:0]          i_dat,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic [CTL_BITS-1:0]   i_ctl,
    output logic                  o_val,
    input  logic                  i_rdy,
    output logic [12*381-1:0]     o_fe12,
    output logic [CTL_BITS-1:0]   o_ctl,
    output logic                  o_err
);
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [3:0] LAST_IDX   = 4'd11;

    logic [1:0]          state;
    logic [3:0]          cnt;
    logic                rdy_en;
    logic [CTL_BITS-1:0] ctl_q;
    logic                err_q;

    logic                accept;
    logic                collect_beat;
    logic                handshake;
    logic                restart;
    logic [3:0]          idx;
    logic                range_err;
    logic                beat_err;

    // rdy_en keeps o_rdy low through reset and for the remainder of the release cycle.
    assign o_rdy        = rdy_en && (state != ST_HOLD);
    assign o_val        = (state == ST_HOLD);
    assign o_ctl        = ctl_q;
    assign o_err        = o_val && err_q;
    assign accept       = i_val && o_rdy;
    assign collect_beat = accept && (state == ST_COLLECT);
    assign handshake    = o_val && i_rdy;

    // A sop mid-frame restarts the frame, so the beat lands in slot 0.
    assign restart   = i_sop && (cnt != 4'd0);
    assign idx       = restart ? 4'd0 : cnt;
    assign range_err = CHECK_RANGE && (i_dat >= P);
    assign beat_err  = restart
                    || ((cnt == 4'd0) && !i_sop)
                    || (i_eop && (idx != LAST_IDX))
                    || (!i_eop && (idx == LAST_IDX))
                    || range_err;

    // Sequencing FSM, slot counter, sticky frame error and captured control word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_COLLECT;
            cnt    <= 4'd0;
            rdy_en <= 1'b0;
            ctl_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                ST_COLLECT: begin
                    if (collect_beat) begin
                        if (idx == 4'd0) ctl_q <= i_ctl;
                        if (beat_err) err_q <= 1'b1;
                        if (i_eop) begin
                            state <= ST_HOLD;
                        end else if (idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            cnt <= idx + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && i_eop) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_rdy) begin
                        state <= ST_COLLECT;
                        cnt   <= 4'd0;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    for (genvar w = 0; w < 12; w++) begin : g_word
        bls12_381_pkg::fe_t word_q;

        // Slot w: cleared on release or restart, loaded when the beat index matches.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                word_q <= '0;
            end else if (handshake) begin
                word_q <= '0;
            end else if (collect_beat) begin
                if (idx == 4'(w)) word_q <= i_dat;
                else if (restart) word_q <= '0;
            end
        end

        assign o_fe12[w*381 +: 381] = word_q;
    end

endmodule

// File: tb/tb_bls12_381_fe12_stream_rx.sv
// Bench for bls12_381_fe12_stream_rx: a range-checking and a non-checking instance
// share one stimulus stream; a queue-based frame model predicts every output frame.
module tb_bls12_381_fe12_stream_rx;
    typedef logic [380:0] fe_t;
    localparam fe_t P   = bls12_381_pkg::P;
    localparam int  FEW = 12 * 381;
    localparam int  NV  = 9;

    typedef struct packed {
        logic [FEW-1:0] fe;
        logic [7:0]     ctl;
        logic           eb;
        logic           er;
    } frame_t;

    typedef struct {
        int  n;
        int  eop_at;
        bit  no_sop;
        int  big_at;
        fe_t big;
        bit  exp_err;
        bit  exp_err_nr;
    } vec_t;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_val = 1'b0;
    logic           i_sop = 1'b0;
    logic           i_eop = 1'b0;
    logic           i_rdy = 1'b1;
    fe_t            i_dat = '0;
    logic [7:0]     i_ctl = '0;
    logic           o_rdy, o_val, o_err;
    logic [FEW-1:0] o_fe12;
    logic [7:0]     o_ctl;
    logic           n_rdy, n_val, n_err;
    logic [FEW-1:0] n_fe12;
    logic [7:0]     n_ctl;

    int tests = 0;
    int fails = 0;

    bls12_381_fe12_stream_rx #(.CTL_BITS(8), .CHECK_RANGE(1'b1)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_dat(i_dat),
        .i_sop(i_sop), .i_eop(i_eop), .i_ctl(i_ctl), .o_val(o_val), .i_rdy(i_rdy),
        .o_fe12(o_fe12), .o_ctl(o_ctl), .o_err(o_err));

    bls12_381_fe12_stream_rx #(.CTL_BITS(8), .CHECK_RANGE(1'b0)) u_nr (
        .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(n_rdy), .i_dat(i_dat),
        .i_sop(i_sop), .i_eop(i_eop), .i_ctl(i_ctl), .o_val(n_val), .i_rdy(i_rdy),
        .o_fe12(n_fe12), .o_ctl(n_ctl), .o_err(n_err));

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test want finish before 400000");
        $fatal(1);
    end

    task automatic chk(input string nm, input fe_t act, input fe_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One comparison over all 12 words; reports the lowest differing word.
    task automatic chk_fe(input string nm, input logic [FEW-1:0] act, input logic [FEW-1:0] exp);
        int bad;
        bad = 0;
        for (int w = 11; w >= 0; w--)
            if (act[w*381 +: 381] !== exp[w*381 +: 381]) bad = w;
        chk($sformatf("%s.w%0d", nm, bad), act[bad*381 +: 381], exp[bad*381 +: 381]);
    endtask

    // ---------------- reference model ----------------
    fe_t        cur_q[$];
    logic [7:0] cur_ctl = '0;
    bit         cur_eb = 0, cur_er = 0, dropping = 0, holding = 0, pend_lat = 0;
    frame_t     exp_q[$];
    frame_t     cur_exp;

    task automatic finish_frame();
        frame_t f;
        f.fe = '0;
        foreach (cur_q[i]) f.fe[i*381 +: 381] = cur_q[i];
        f.ctl = cur_ctl;
        f.eb  = cur_eb;
        f.er  = cur_er;
        exp_q.push_back(f);
        cur_q.delete();
        cur_eb   = 0;
        cur_er   = 0;
        dropping = 0;
        pend_lat = 1;
    endtask

    task automatic model_beat(input fe_t d, input bit sop, input bit eop, input logic [7:0] ctl);
        if (dropping) begin
            if (eop) finish_frame();
            return;
        end
        if (sop && cur_q.size() != 0) begin
            cur_q.delete();
            cur_eb = 1;
        end
        if (cur_q.size() == 0) begin
            cur_ctl = ctl;
            if (!sop) cur_eb = 1;
        end
        cur_q.push_back(d);
        if (d >= P) cur_er = 1;
        if (eop) begin
            if (cur_q.size() != 12) cur_eb = 1;
            finish_frame();
        end else if (cur_q.size() == 12) begin
            cur_eb   = 1;
            dropping = 1;
        end
    endtask

    // Monitor: samples mid-cycle, checks outputs against the model, feeds accepted beats.
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("rst_val", fe_t'(o_val), '0);
            chk("rst_rdy", fe_t'(o_rdy), '0);
            chk("rst_err", fe_t'(o_err), '0);
            chk("rst_ctl", fe_t'(o_ctl), '0);
            chk_fe("rst_fe12", o_fe12, '0);
            chk("rst_nr_rdy", fe_t'(n_rdy), '0);
            cur_q.delete();
            exp_q.delete();
            cur_eb = 0; cur_er = 0; dropping = 0; holding = 0; pend_lat = 0;
        end else begin
            if (pend_lat) begin
                chk("latency_val", fe_t'(o_val), fe_t'(1));
                pend_lat = 0;
            end
            if (o_val) begin
                chk("hold_rdy", fe_t'(o_rdy), '0);
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got o_val=1 want no frame");
                        cur_exp = '0;
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    holding = 1;
                end
                chk_fe("frame_fe12", o_fe12, cur_exp.fe);
                chk("frame_ctl", fe_t'(o_ctl), fe_t'(cur_exp.ctl));
                chk("frame_err", fe_t'(o_err), fe_t'(cur_exp.eb | cur_exp.er));
                chk("nr_val", fe_t'(n_val), fe_t'(1));
                chk_fe("nr_fe12", n_fe12, cur_exp.fe);
                chk("nr_ctl", fe_t'(n_ctl), fe_t'(cur_exp.ctl));
                chk("nr_err", fe_t'(n_err), fe_t'(cur_exp.eb));
                if (i_rdy) holding = 0;
            end
            if (i_val && o_rdy) model_beat(i_dat, i_sop, i_eop, i_ctl);
        end
    end

    // ---------------- drivers ----------------
    bit rand_rdy = 0;

    always @(posedge i_clk) begin
        #1;
        if (rand_rdy) i_rdy = ($urandom_range(0, 2) != 0);
    end

    function automatic fe_t rand_fe();
        fe_t x = '0;
        for (int i = 0; i < 12; i++) x = {x[348:0], 32'($urandom)};
        x[380:379] = 2'b00;
        return x;
    endfunction

    // Called and returns at posedge+1; holds the beat until it is accepted.
    task automatic beat(input fe_t d, input bit sop, input bit eop, input logic [7:0] ctl);
        int n;
        n = 0;
        i_val = 1'b1; i_dat = d; i_sop = sop; i_eop = eop; i_ctl = ctl;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_rdy && n < 400);
        if (!o_rdy) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: got o_rdy=0 want accept within 400 cycles");
        end
        @(posedge i_clk);
        #1;
        i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!o_val && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_val) begin
            tests++;
            fails++;
            $display("FAIL out_timeout: got o_val=0 want frame within 50 cycles");
        end
    endtask

    task automatic pulse_rst();
        i_rst = 1'b1;
        i_val = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rst_rdy_held", fe_t'(o_rdy), '0);
        i_rst = 1'b0;
        chk("rdy_at_release", fe_t'(o_rdy), '0);
        @(posedge i_clk);
        #1;
        chk("rdy_after_edge", fe_t'(o_rdy), fe_t'(1));
    endtask

    // ---------------- test sequence ----------------
    vec_t       vecs[NV];
    fe_t        d;
    fe_t        ones;
    int         kind, n, eop_at, msop, r;
    bit         nosop;

    initial begin
        ones = '1;
        vecs[0] = '{n:12, eop_at:11, no_sop:1'b0, big_at:-1, big:'0,    exp_err:1'b0, exp_err_nr:1'b0};
        vecs[1] = '{n:5,  eop_at:4,  no_sop:1'b0, big_at:-1, big:'0,    exp_err:1'b1, exp_err_nr:1'b1};
        vecs[2] = '{n:15, eop_at:14, no_sop:1'b0, big_at:-1, big:'0,    exp_err:1'b1, exp_err_nr:1'b1};
        vecs[3] = '{n:12, eop_at:11, no_sop:1'b0, big_at:3,  big:P,     exp_err:1'b1, exp_err_nr:1'b0};
        vecs[4] = '{n:12, eop_at:11, no_sop:1'b0, big_at:3,  big:ones,  exp_err:1'b1, exp_err_nr:1'b0};
        vecs[5] = '{n:12, eop_at:11, no_sop:1'b0, big_at:5,  big:P-1,   exp_err:1'b0, exp_err_nr:1'b0};
        vecs[6] = '{n:1,  eop_at:0,  no_sop:1'b0, big_at:-1, big:'0,    exp_err:1'b1, exp_err_nr:1'b1};
        vecs[7] = '{n:12, eop_at:11, no_sop:1'b1, big_at:-1, big:'0,    exp_err:1'b1, exp_err_nr:1'b1};
        vecs[8] = '{n:11, eop_at:10, no_sop:1'b0, big_at:-1, big:'0,    exp_err:1'b1, exp_err_nr:1'b1};

        repeat (2) @(posedge i_clk);
        #1;
        pulse_rst();

        // Clean frame, data n+1, control 5A.
        for (int b = 0; b < 12; b++) beat(fe_t'(b + 1), b == 0, b == 11, 8'h5A);
        chk("s1_val_next_cycle", fe_t'(o_val), fe_t'(1));
        for (int w = 0; w < 12; w++)
            chk($sformatf("s1_word%0d", w), o_fe12[w*381 +: 381], fe_t'(w + 1));
        chk("s1_ctl", fe_t'(o_ctl), fe_t'(8'h5A));
        chk("s1_err", fe_t'(o_err), '0);
        @(posedge i_clk);
        #1;

        // Table of frame shapes.
        for (int v = 0; v < NV; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                d = (b == vecs[v].big_at) ? vecs[v].big : rand_fe();
                beat(d, (b == 0) && !vecs[v].no_sop, b == vecs[v].eop_at, 8'($urandom));
            end
            wait_out();
            chk($sformatf("vec%0d_err", v), fe_t'(o_err), fe_t'(vecs[v].exp_err));
            chk($sformatf("vec%0d_nr_err", v), fe_t'(n_err), fe_t'(vecs[v].exp_err_nr));
            @(posedge i_clk);
            #1;
        end

        // Backpressure: output held 20 cycles while a 13th beat is offered.
        i_rdy = 1'b0;
        for (int b = 0; b < 12; b++) beat(rand_fe(), b == 0, b == 11, 8'hC3);
        d = rand_fe();
        i_val = 1'b1; i_dat = d; i_sop = 1'b1; i_eop = 1'b0; i_ctl = 8'h77;
        repeat (20) begin
            @(negedge i_clk);
            chk("bp_val", fe_t'(o_val), fe_t'(1));
            chk("bp_rdy", fe_t'(o_rdy), '0);
        end
        @(posedge i_clk);
        #1;
        i_rdy = 1'b1;
        beat(d, 1'b1, 1'b0, 8'h77);
        for (int b = 1; b < 12; b++) beat(rand_fe(), 1'b0, b == 11, 8'h00);
        wait_out();
        chk("bp_next_ctl", fe_t'(o_ctl), fe_t'(8'h77));
        chk("bp_next_word0", o_fe12[380:0], d);
        @(posedge i_clk);
        #1;

        // sop in the middle of a frame restarts it with the new control word.
        for (int b = 0; b < 4; b++) beat(rand_fe(), b == 0, 1'b0, 8'h11);
        d = rand_fe();
        beat(d, 1'b1, 1'b0, 8'h33);
        for (int b = 1; b < 12; b++) beat(rand_fe(), 1'b0, b == 11, 8'h00);
        wait_out();
        chk("restart_ctl", fe_t'(o_ctl), fe_t'(8'h33));
        chk("restart_err", fe_t'(o_err), fe_t'(1));
        chk("restart_word0", o_fe12[380:0], d);
        @(posedge i_clk);
        #1;

        // Reset mid-frame, then a clean frame.
        for (int b = 0; b < 7; b++) beat(ones, b == 0, 1'b0, 8'hEE);
        pulse_rst();
        for (int b = 0; b < 12; b++) beat(fe_t'(b + 100), b == 0, b == 11, 8'h42);
        wait_out();
        chk("post_rst_err", fe_t'(o_err), '0);
        chk("post_rst_ctl", fe_t'(o_ctl), fe_t'(8'h42));
        chk("post_rst_word6", o_fe12[6*381 +: 381], fe_t'(106));
        @(posedge i_clk);
        #1;

        // Randomised frames with random downstream backpressure.
        rand_rdy = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 7);
            n = 12; eop_at = 11; nosop = 0; msop = -1;
            case (kind)
                4: begin msop = $urandom_range(1, 10); n = msop + 12; eop_at = n - 1; end
                5: begin n = $urandom_range(1, 11); eop_at = n - 1; end
                6: begin n = $urandom_range(13, 16); eop_at = n - 1; end
                7: nosop = 1;
                default: ;
            endcase
            for (int b = 0; b < n; b++) begin
                r = $urandom_range(0, 15);
                if (r == 0) d = P;
                else if (r == 1) d = ones;
                else if (r == 2) d = P - 1;
                else d = rand_fe();
                beat(d, ((b == 0) && !nosop) || (b == msop), b == eop_at, 8'($urandom));
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_rdy = 0;
        @(posedge i_clk);
        #2;
        i_rdy = 1'b1;
        idle(30);
        chk("all_frames_seen", fe_t'(exp_q.size()), '0);
        chk("model_idle", fe_t'(cur_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bls12_381_fe12_stream_rx.md
BLS12_381_FE12_STREAM_RX -- requirements
Module: bls12_381_fe12_stream_rx

Interface
REQ-001 Parameter CTL_BITS, default 8: width of the sideband control field captured per frame.
REQ-002 Parameter P, default bls12_381_pkg::P: field modulus used for the range check.
REQ-003 Parameter CHECK_RANGE, default 1: 1 enables the word >= P error check; 0 disables it.
REQ-004 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-high.
REQ-006 i_val  input  1  input beat valid.
REQ-007 o_rdy  output  1  input beat ready.
REQ-008 i_dat  input  381  one Fp word, fe_t.
REQ-009 i_sop  input  1  first beat of a frame.
REQ-010 i_eop  input  1  last beat of a frame.
REQ-011 i_ctl  input  CTL_BITS  sideband control, sampled on the first beat.
REQ-012 o_val  output  1  assembled fe12 valid.
REQ-013 i_rdy  input  1  downstream ready for the fe12.
REQ-014 o_fe12  output  12*381  assembled fe12_t.
REQ-015 o_ctl  output  CTL_BITS  control captured from the frame's first beat.
REQ-016 o_err  output  1  frame error flag, qualified by o_val.

Function
REQ-017 A beat SHALL be accepted only in a cycle where i_val and o_rdy are both high.
REQ-018 Beat index n (0..11) SHALL map to coefficient f[i][j][k], where n = i*6 + j*2 + k.
REQ-019 Beat index n SHALL be stored at o_fe12[n*381 +: 381].
REQ-020 The FSM SHALL have three states: COLLECT, HOLD and DRAIN.
REQ-021 o_rdy SHALL be 1 in COLLECT and DRAIN, and 0 in HOLD.
REQ-022 o_val SHALL be 1 only in HOLD.
REQ-023 COLLECT: each accepted beat SHALL be written at index cnt, then cnt SHALL increment.
REQ-024 COLLECT: i_ctl SHALL be latched when cnt==0.
REQ-025 The normal frame is 12 beats, with sop on beat 0 and eop on beat 11.
REQ-026 Accepting beat 11 with eop SHALL move the FSM to HOLD, with o_val high the next cycle (1-cycle latency).
REQ-027 HOLD: when o_val and i_rdy are both high, the FSM SHALL move to COLLECT with cnt=0, all 12 words cleared and the error flag cleared.
REQ-028 The first beat of the next frame SHALL be accepted no earlier than the cycle after the handshake (1 bubble per frame).
REQ-029 HOLD: o_fe12, o_ctl and o_err SHALL stay stable until the handshake.
REQ-030 Early eop (eop at cnt<11): the FSM SHALL go to HOLD with o_err=1; unwritten words SHALL read 0.
REQ-031 sop at cnt!=0: the partial frame SHALL be discarded (words zeroed) and this beat stored as index 0.
REQ-032 In the sop-at-cnt!=0 case, i_ctl SHALL be re-latched and the error flag set for the resulting frame.
REQ-033 sop missing at cnt==0: the beat SHALL be accepted as index 0 and the error flag set.
REQ-034 Beat 11 without eop: the FSM SHALL go to DRAIN with the error flag set.
REQ-035 DRAIN: beats SHALL be accepted and discarded until a beat with eop is accepted, then the FSM SHALL go to HOLD.
REQ-036 A beat with sop and eop both high at cnt==0 SHALL produce a 1-word frame with o_err=1.
REQ-037 With CHECK_RANGE=1, any stored word with value >= P SHALL set the error flag; the word SHALL be stored unmodified.
REQ-038 The error flag SHALL be sticky per frame, be presented as o_err in HOLD, and clear on the output handshake.
REQ-039 The counter SHALL be 4 bits and never exceed 11; no wrap-around SHALL occur.

Reset
REQ-040 Asserting i_rst at any time, including mid-frame or in HOLD, SHALL immediately force the FSM to COLLECT with cnt=0.
REQ-041 Under reset, o_val, o_err, o_fe12 and o_ctl SHALL be 0 and the partial frame SHALL be discarded.
REQ-042 Under reset, o_rdy SHALL be 0 while i_rst is high and 1 from the first clock edge after release.

Verification
REQ-043 Scenario: 12 beats with data = n+1, sop on beat 0, eop on beat 11, i_ctl=8'h5A, i_rdy=1 -> o_val one cycle after beat 11; word n = n+1; o_ctl=8'h5A; o_err=0.
REQ-044 Scenario: i_rdy held 0 for 20 cycles after the frame completes -> o_val, o_fe12 and o_ctl stable for all 20 cycles, o_rdy=0 throughout, and a 13th beat is offered but not accepted.
REQ-045 Scenario: 5 beats with eop on beat 4 -> o_err=1, words 0..4 correct, words 5..11 = 0.
REQ-046 Scenario: 12 beats without eop, then 3 more beats with eop on the last -> one output frame with o_err=1, words 0..11 from the first 12 beats, extra beats discarded.
REQ-047 Scenario: beat 3 carries P, or 381'h1FF..F -> o_err=1 and the word is stored as given; repeated with CHECK_RANGE=0 -> o_err=0.
REQ-048 Scenario: i_rst pulsed after beat 6, then a clean 12-beat frame -> clean frame output with no contamination from the partial frame, and o_err=0.
